// File: rtl/exec_pkg.sv
// Shared types and constants for the vector execute stage and its dispatcher.
package exec_pkg;

    localparam int EXEC_N     = 32;
    localparam int EXEC_LANES = 24;
    localparam int EXEC_OPW   = 4;

    typedef logic [EXEC_LANES*EXEC_N-1:0] exec_vec_t;
    typedef logic [EXEC_LANES-1:0]        exec_mask_t;
    typedef logic [EXEC_OPW-1:0]          exec_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dispatch_state_t;

    localparam exec_op_t OP_SHL       = 4'b0111;
    localparam exec_op_t OP_NOP_VALID = 4'b0100;
    localparam exec_op_t OP_SHR       = 4'b1000;

    // Extract one lane of a lane-packed vector (lane 0 in the low bits).
    function automatic logic [EXEC_N-1:0] lane_of(input exec_vec_t v, input int idx);
        return v[idx*EXEC_N +: EXEC_N];
    endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// BUSY-cycle watchdog: counts enabled cycles from 1 and flags the TIMEOUT-th one.
module dispatch_watchdog
    import exec_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds (BUSY cycle number - 1), so the first BUSY cycle can already expire when TIMEOUT=1.
    always_comb begin
        expired = enable && !clear && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exec_dispatch.sv
// Issue/writeback controller between decode and vector execute.
// Optional perf counters when EXEC_DISPATCH_PERF_EN is defined.
module exec_dispatch
    import exec_pkg::*;
#(
    parameter int N            = 32,
    parameter int WIDTH_VECTOR = 24,
    parameter int WIDTH_OPCODE = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                        clk,
    input  logic                        rstn,
    // valid/ready on both sides: a transfer happens on a clock edge where valid && ready.
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH_VECTOR-1:0]     in_mask,
    input  logic [WIDTH_OPCODE-1:0]     in_opcode,
    input  logic [WIDTH_VECTOR*N-1:0]   in_dataA,
    input  logic [WIDTH_VECTOR*N-1:0]   in_dataB,
    input  logic [WIDTH_VECTOR-1:0]     in_imm,
    output logic [WIDTH_VECTOR-1:0]     exec_enable,
    output logic [WIDTH_OPCODE-1:0]     exec_opcode,
    output logic [WIDTH_VECTOR*N-1:0]   exec_dataA,
    output logic [WIDTH_VECTOR*N-1:0]   exec_dataB,
    output logic [WIDTH_VECTOR-1:0]     exec_imm,
    input  logic                        exec_valid,
    input  logic                        exec_zero,
    input  logic [WIDTH_VECTOR*N-1:0]   exec_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH_VECTOR*N-1:0]   out_data,
    output logic                        out_zero,
    output logic                        out_err,
    output logic [1:0]                  dbg_state
`ifdef EXEC_DISPATCH_PERF_EN
    ,
    output logic [31:0]                 perf_ops,
    output logic [31:0]                 perf_busy
`endif
);

    localparam int DW = WIDTH_VECTOR * N;

    dispatch_state_t state_q, state_d;

    logic [WIDTH_VECTOR-1:0] mask_q;
    logic [WIDTH_OPCODE-1:0] opcode_q;
    logic [DW-1:0]           dataA_q, dataB_q;
    logic [WIDTH_VECTOR-1:0] imm_q;
    logic [DW-1:0]           out_data_q, out_data_d;
    logic                    out_zero_q, out_zero_d;
    logic                    out_err_q, out_err_d;

    logic load;
    logic capture;
    logic retire;
    logic wd_expired;

    dispatch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (state_q != BUSY),
        .enable (state_q == BUSY),
        .expired(wd_expired)
    );

    assign retire = (state_q == DONE) && out_ready;

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        capture    = 1'b0;
        out_data_d = out_data_q;
        out_zero_d = out_zero_q;
        out_err_d  = out_err_q;
        in_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = rstn;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A completion on the expiry cycle still counts as a normal result.
                if (exec_valid) begin
                    capture    = 1'b1;
                    out_data_d = exec_data;
                    out_zero_d = exec_zero;
                    out_err_d  = 1'b0;
                    state_d    = DONE;
                end else if (wd_expired) begin
                    capture    = 1'b1;
                    out_data_d = '0;
                    out_zero_d = 1'b0;
                    out_err_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                in_ready = rstn && out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q   <= '0;
            opcode_q <= '0;
            dataA_q  <= '0;
            dataB_q  <= '0;
            imm_q    <= '0;
        end else if (load) begin
            mask_q   <= in_mask;
            opcode_q <= in_opcode;
            dataA_q  <= in_dataA;
            dataB_q  <= in_dataB;
            imm_q    <= in_imm;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_data_q <= '0;
            out_zero_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else if (capture) begin
            out_data_q <= out_data_d;
            out_zero_q <= out_zero_d;
            out_err_q  <= out_err_d;
        end
    end

    // Lanes are only enabled while BUSY, which guarantees an all-zero gap in DONE.
    assign exec_enable = (state_q == BUSY) ? mask_q : '0;
    assign exec_opcode = opcode_q;
    assign exec_dataA  = dataA_q;
    assign exec_dataB  = dataB_q;
    assign exec_imm    = imm_q;
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_data_q;
    assign out_zero    = out_zero_q;
    assign out_err     = out_err_q;
    assign dbg_state   = state_q;

`ifdef EXEC_DISPATCH_PERF_EN
    logic [31:0] perf_ops_q, perf_busy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (retire && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if ((state_q == BUSY) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_exec_dispatch.sv
// Scoreboard bench for exec_dispatch with a small execute-stage responder.
module tb_exec_dispatch;

  localparam int N    = 32;
  localparam int L    = 24;
  localparam int OPW  = 4;
  localparam int TOUT = 8;
  localparam int W    = L * N;

  logic           clk;
  logic           rstn;
  logic           in_valid;
  logic           in_ready;
  logic [L-1:0]   in_mask;
  logic [OPW-1:0] in_opcode;
  logic [W-1:0]   in_dataA;
  logic [W-1:0]   in_dataB;
  logic [L-1:0]   in_imm;
  logic [L-1:0]   exec_enable;
  logic [OPW-1:0] exec_opcode;
  logic [W-1:0]   exec_dataA;
  logic [W-1:0]   exec_dataB;
  logic [L-1:0]   exec_imm;
  logic           exec_valid;
  logic           exec_zero;
  logic [W-1:0]   exec_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_zero;
  logic           out_err;
  logic [1:0]     dbg_state;
`ifdef EXEC_DISPATCH_PERF_EN
  logic [31:0]    perf_ops;
  logic [31:0]    perf_busy;
`endif

  exec_dispatch #(
    .N(N), .WIDTH_VECTOR(L), .WIDTH_OPCODE(OPW), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mask(in_mask), .in_opcode(in_opcode),
    .in_dataA(in_dataA), .in_dataB(in_dataB), .in_imm(in_imm),
    .exec_enable(exec_enable), .exec_opcode(exec_opcode),
    .exec_dataA(exec_dataA), .exec_dataB(exec_dataB), .exec_imm(exec_imm),
    .exec_valid(exec_valid), .exec_zero(exec_zero), .exec_data(exec_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err),
    .dbg_state(dbg_state)
`ifdef EXEC_DISPATCH_PERF_EN
    , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected results are packed {err, zero, data}.
  logic [W+1:0] exp_q[$];
  int           pend_lat[$];
  logic [W-1:0] pend_data[$];
  logic         pend_zero[$];

  // ---------------- execute-stage responder ----------------
  // Raises exec_valid combinationally in BUSY cycle cur_lat (0 = never).
  int           bcnt;
  int           cur_lat;
  logic [W-1:0] cur_data;
  logic         cur_zero;

  assign exec_valid = (bcnt != 0) && (bcnt == cur_lat);
  assign exec_data  = cur_data;
  assign exec_zero  = cur_zero;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt <= 0;
    end else if (in_valid && in_ready) begin
      bcnt <= 1;
      if (pend_lat.size() > 0) begin
        cur_lat  <= pend_lat.pop_front();
        cur_data <= pend_data.pop_front();
        cur_zero <= pend_zero.pop_front();
      end
    end else if (bcnt != 0) begin
      bcnt <= (exec_valid || bcnt >= TOUT) ? 0 : bcnt + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", {out_err, out_zero, out_data});
      end else begin
        chk("result", {out_err, out_zero, out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [L-1:0] mask, input logic [OPW-1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [L-1:0] imm,
                         input int lat, input logic [W-1:0] data, input logic zero);
    bit taken = 0;
    in_mask   = mask;
    in_opcode = op;
    in_dataA  = a;
    in_dataB  = b;
    in_imm    = imm;
    in_valid  = 1'b1;
    pend_lat.push_back(lat);
    pend_data.push_back(data);
    pend_zero.push_back(zero);
    if (lat != 0 && lat <= TOUT) exp_q.push_back({1'b0, zero, data});
    else                         exp_q.push_back({1'b1, 1'b0, {W{1'b0}}});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1;
        break;
      end
    end
    if (!taken) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges (first = cycle after the accept edge) until out_valid.
  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] va, vb, vr;
  logic [L-1:0] hist[10];
  int           n;

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_opcode = '0;
    in_dataA  = '0;
    in_dataB  = '0;
    in_imm    = '0;
    out_ready = 1'b1;
    cur_lat   = 0;
    cur_data  = '0;
    cur_zero  = 1'b0;
    va = {L{32'h1234_0001}};
    vb = {L{32'h0000_00FF}};

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exec_enable", exec_enable, 0);
    chk("rst_out", {out_err, out_zero, out_data}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Single op: valid in BUSY cycle 4
    idle_cycles(1);
    vr = {L{32'h0001_0000}};
    send_op(24'hFFFFFF, 4'b0001, va, vb, 24'h00_0A5C, 4, vr, 1'b0);
    @(negedge clk);
    chk("busy_enable", exec_enable, 24'hFFFFFF);
    chk("busy_opcode", exec_opcode, 4'b0001);
    chk("busy_dataA", exec_dataA, va);
    chk("busy_dataB", exec_dataB, vb);
    chk("busy_imm", exec_imm, 24'h00_0A5C);
    chk("busy_in_ready", in_ready, 0);
    wait_out(n);
    chk("single_latency", n + 1, 5);
    chk("done_enable", exec_enable, 0);
    idle_cycles(2);

    // Combinational valid in first BUSY cycle
    send_op(24'h000000, 4'b1000, va, vb, 24'h0, 1, {W{1'b0}}, 1'b1);
    wait_out(n);
    chk("comb_latency", n, 2);
    chk("comb_done_enable", exec_enable, 0);
    idle_cycles(2);

    // Back-to-back: three ops, 2 BUSY cycles each, one all-zero gap between
    fork
      begin
        send_op(24'hABCDEF, 4'b0011, va, vb, 24'h1, 2, {L{32'hDEAD_0001}}, 1'b0);
        send_op(24'hABCDEF, 4'b0011, vb, va, 24'h2, 2, {L{32'hDEAD_0002}}, 1'b1);
        send_op(24'hABCDEF, 4'b0011, va, va, 24'h3, 2, {L{32'hDEAD_0003}}, 1'b0);
      end
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          hist[i] = exec_enable;
        end
      end
    join
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b_enable_%0d", i), hist[i], (i % 3 == 0) ? 24'h0 : 24'hABCDEF);
    end
    idle_cycles(2);

    // Backpressure in DONE
    out_ready = 1'b0;
    vr = {L{32'h5555_AAAA}};
    send_op(24'h0F0F0F, 4'b0010, va, vb, 24'h7, 2, vr, 1'b1);
    wait_out(n);
    chk("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_opcode = 4'b1111;
      in_dataA  = vb;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", {out_err, out_zero, out_data}, {1'b0, 1'b1, vr});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_retired", out_valid, 0);
    chk("bp_idle_opcode", exec_opcode, 4'b0010);
    idle_cycles(1);

    // Watchdog: never completes, then completes exactly in BUSY cycle 8
    send_op(24'h00FF00, 4'b0101, va, vb, 24'h0, 0, {L{32'hFFFF_FFFF}}, 1'b1);
    wait_out(n);
    chk("tout_latency", n, 1 + TOUT);
    idle_cycles(2);
    send_op(24'h00FF00, 4'b0101, va, vb, 24'h0, TOUT, {L{32'h0BAD_F00D}}, 1'b0);
    wait_out(n);
    chk("tout_edge_latency", n, 1 + TOUT);
    idle_cycles(2);

    // Reset in BUSY cycle 2
    send_op(24'h123456, 4'b0110, va, vb, 24'h9, 0, {W{1'b0}}, 1'b0);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("mid_rst_enable", exec_enable, 0);
    chk("mid_rst_opcode", exec_opcode, 0);
    chk("mid_rst_dataA", exec_dataA, 0);
    chk("mid_rst_out", {out_valid, out_err, out_zero, out_data}, 0);
    chk("mid_rst_in_ready", in_ready, 0);
`ifdef EXEC_DISPATCH_PERF_EN
    chk("perf_ops_rst", perf_ops, 0);
    chk("perf_busy_rst", perf_busy, 0);
`endif
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    idle_cycles(1);
    send_op(24'h000111, 4'b0111, vb, va, 24'h4, 3, {L{32'h7777_0000}}, 1'b0);
    wait_out(n);
    chk("post_rst_latency", n, 4);
    idle_cycles(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
